sh_onchip_intc: RTL and testbench

- On-chip peripheral interrupt stage that sits directly downstream of the SCI and its sibling peripherals (FRT, WDT, DIVU, DMAC0/1).
- Owns the IPRA/IPRB priority registers and the VCRA/VCRB/VCRC/VCRD/VCRWDT/VCRDIV vector registers on IBUS.
- Resolves the highest-priority pending source and presents its level and vector to the CPU core through a request/acknowledge handshake.

---
 rtl/sh_onchip_intc_pkg.sv | 68 ++++++
 rtl/sh_intc_prio_sel.sv | 26 ++
 rtl/sh_onchip_intc.sv | 161 ++++++++++++++++
 tb/tb_sh_onchip_intc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sh_onchip_intc_pkg.sv
// rtl/sh_onchip_intc_pkg.sv - register layouts, masks, addresses and source indices for the on-chip INTC
package sh_onchip_intc_pkg;

  typedef struct packed {
    logic [3:0] divu;
    logic [3:0] dmac;
    logic [3:0] wdt;
    logic [3:0] rsvd;
  } IPRA_t;

  typedef struct packed {
    logic [3:0] sci;
    logic [3:0] frt;
    logic [7:0] rsvd;
  } IPRB_t;

  typedef struct packed {
    logic       rsvd_h;
    logic [6:0] hi;
    logic       rsvd_l;
    logic [6:0] lo;
  } VCR_t;

  typedef struct packed {
    logic [24:0] rsvd;
    logic [6:0]  vec;
  } VCRDIV_t;

  // Index order doubles as the fixed tie-break order, 0 wins
  typedef enum logic [3:0] {
    SRC_DIVU, SRC_DMA0, SRC_DMA1, SRC_ITI, SRC_ERI, SRC_RXI,
    SRC_TXI, SRC_TEI, SRC_ICI, SRC_OCI, SRC_OVI
  } INTC_SRC_t;

  localparam int N_SRC = 11;

  localparam logic [15:0] IPRA_INIT    = 16'h0000;
  localparam logic [15:0] IPRB_INIT    = 16'h0000;
  localparam logic [15:0] VCR_INIT     = 16'h0000;
  localparam logic [31:0] VCRDIV_INIT  = 32'h0000_0000;

  localparam logic [15:0] IPRA_WMASK   = 16'hFFF0;
  localparam logic [15:0] IPRB_WMASK   = 16'hFF00;
  localparam logic [15:0] VCR_WMASK    = 16'h7F7F;
  localparam logic [15:0] VCRH_WMASK   = 16'h7F00;
  localparam logic [31:0] VCRDIV_WMASK = 32'h0000_007F;

  localparam logic [15:0] IPRA_RMASK   = IPRA_WMASK;
  localparam logic [15:0] IPRB_RMASK   = IPRB_WMASK;
  localparam logic [15:0] VCR_RMASK    = VCR_WMASK;
  localparam logic [15:0] VCRH_RMASK   = VCRH_WMASK;
  localparam logic [31:0] VCRDIV_RMASK = VCRDIV_WMASK;

  localparam logic [31:0] ADDR_IPRA    = 32'hFFFF_FEE2;
  localparam logic [31:0] ADDR_IPRB    = 32'hFFFF_FE60;
  localparam logic [31:0] ADDR_VCRA    = 32'hFFFF_FE62;
  localparam logic [31:0] ADDR_VCRB    = 32'hFFFF_FE64;
  localparam logic [31:0] ADDR_VCRC    = 32'hFFFF_FE66;
  localparam logic [31:0] ADDR_VCRD    = 32'hFFFF_FE68;
  localparam logic [31:0] ADDR_VCRWDT  = 32'hFFFF_FEE4;
  localparam logic [31:0] ADDR_VCRDIV  = 32'hFFFF_FF0C;

  function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] di,
                                          input logic [15:0] bm, input logic [15:0] mask);
    return ((old & ~bm) | (di & bm)) & mask;
  endfunction

endpackage

// File: rtl/sh_intc_prio_sel.sv
// rtl/sh_intc_prio_sel.sv - combinational highest-level select with fixed tie order
module sh_intc_prio_sel
  import sh_onchip_intc_pkg::*;
(
  input  logic [4*N_SRC-1:0] lvl_in,
  input  logic [8*N_SRC-1:0] vec_in,
  output logic [3:0]         win_lvl,
  output logic [7:0]         win_vec,
  output logic               win_valid
);

  // Scan from lowest tie rank upward with >= so the lower index wins a tie
  always_comb begin
    win_lvl   = 4'd0;
    win_vec   = 8'd0;
    win_valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (lvl_in[4*i +: 4] != 4'd0 && lvl_in[4*i +: 4] >= win_lvl) begin
        win_lvl   = lvl_in[4*i +: 4];
        win_vec   = vec_in[8*i +: 8];
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sh_onchip_intc.sv
// rtl/sh_onchip_intc.sv - on-chip peripheral interrupt controller: IPR/VCR registers, resolution, CPU handshake
module sh_onchip_intc
  import sh_onchip_intc_pkg::*;
#(
  parameter logic [7:0] SPURIOUS_VEC = 8'd24
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [31:0] IBUS_A,
  input  logic [31:0] IBUS_DI,
  output logic [31:0] IBUS_DO,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic        IBUS_BUSY,
  output logic        IBUS_ACT,
  input  logic        SCI_ERI,
  input  logic        SCI_RXI,
  input  logic        SCI_TXI,
  input  logic        SCI_TEI,
  input  logic        FRT_ICI,
  input  logic        FRT_OCI,
  input  logic        FRT_OVI,
  input  logic        WDT_ITI,
  input  logic        DIVU_OVFI,
  input  logic        DMA0_IRQ,
  input  logic        DMA1_IRQ,
  input  logic [7:0]  DMA0_VEC,
  input  logic [7:0]  DMA1_VEC,
  output logic [3:0]  INT_LVL,
  output logic [7:0]  INT_VEC,
  input  logic        INT_ACK
);

  IPRA_t   ipra;
  IPRB_t   iprb;
  VCR_t    vcra, vcrb, vcrc, vcrd, vcrwdt;
  VCRDIV_t vcrdiv;

  logic sel_ipra, sel_iprb, sel_vcra, sel_vcrb, sel_vcrc, sel_vcrd, sel_vcrwdt, sel_vcrdiv;
  logic        wr_en;
  logic [31:0] w_bm;
  logic [15:0] hw_di, hw_bm;
  logic [31:0] rd_mux, reg_do;
  logic        unused_ok;

  assign sel_ipra   = IBUS_A[31:1] == ADDR_IPRA[31:1];
  assign sel_iprb   = IBUS_A[31:1] == ADDR_IPRB[31:1];
  assign sel_vcra   = IBUS_A[31:1] == ADDR_VCRA[31:1];
  assign sel_vcrb   = IBUS_A[31:1] == ADDR_VCRB[31:1];
  assign sel_vcrc   = IBUS_A[31:1] == ADDR_VCRC[31:1];
  assign sel_vcrd   = IBUS_A[31:1] == ADDR_VCRD[31:1];
  assign sel_vcrwdt = IBUS_A[31:1] == ADDR_VCRWDT[31:1];
  assign sel_vcrdiv = IBUS_A[31:2] == ADDR_VCRDIV[31:2];
  assign IBUS_ACT   = sel_ipra | sel_iprb | sel_vcra | sel_vcrb | sel_vcrc |
                      sel_vcrd | sel_vcrwdt | sel_vcrdiv;
  assign IBUS_BUSY  = 1'b0;
  assign unused_ok  = &{1'b0, IBUS_A[0]};

  // Big-endian lanes: halfword at A[1]=0 rides on [31:16], A[1]=1 on [15:0]
  assign wr_en = CE_R & IBUS_REQ & IBUS_WE;
  assign w_bm  = {{8{IBUS_BA[3]}}, {8{IBUS_BA[2]}}, {8{IBUS_BA[1]}}, {8{IBUS_BA[0]}}};
  assign hw_di = IBUS_A[1] ? IBUS_DI[15:0] : IBUS_DI[31:16];
  assign hw_bm = IBUS_A[1] ? w_bm[15:0]    : w_bm[31:16];

  always_ff @(posedge CLK) begin
    if (RST) begin
      ipra   <= IPRA_t'(IPRA_INIT);
      iprb   <= IPRB_t'(IPRB_INIT);
      vcra   <= VCR_t'(VCR_INIT);
      vcrb   <= VCR_t'(VCR_INIT);
      vcrc   <= VCR_t'(VCR_INIT);
      vcrd   <= VCR_t'(VCR_INIT);
      vcrwdt <= VCR_t'(VCR_INIT);
      vcrdiv <= VCRDIV_t'(VCRDIV_INIT);
    end else if (wr_en) begin
      if (sel_ipra)   ipra   <= IPRA_t'(merge16(16'(ipra), hw_di, hw_bm, IPRA_WMASK));
      if (sel_iprb)   iprb   <= IPRB_t'(merge16(16'(iprb), hw_di, hw_bm, IPRB_WMASK));
      if (sel_vcra)   vcra   <= VCR_t'(merge16(16'(vcra), hw_di, hw_bm, VCR_WMASK));
      if (sel_vcrb)   vcrb   <= VCR_t'(merge16(16'(vcrb), hw_di, hw_bm, VCR_WMASK));
      if (sel_vcrc)   vcrc   <= VCR_t'(merge16(16'(vcrc), hw_di, hw_bm, VCR_WMASK));
      if (sel_vcrd)   vcrd   <= VCR_t'(merge16(16'(vcrd), hw_di, hw_bm, VCRH_WMASK));
      if (sel_vcrwdt) vcrwdt <= VCR_t'(merge16(16'(vcrwdt), hw_di, hw_bm, VCRH_WMASK));
      if (sel_vcrdiv) vcrdiv <= VCRDIV_t'({16'h0000, merge16(vcrdiv[15:0], IBUS_DI[15:0],
                                                             w_bm[15:0], VCRDIV_WMASK[15:0])});
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    if (sel_ipra)   rd_mux = {2{16'(ipra) & IPRA_RMASK}};
    if (sel_iprb)   rd_mux = {2{16'(iprb) & IPRB_RMASK}};
    if (sel_vcra)   rd_mux = {2{16'(vcra) & VCR_RMASK}};
    if (sel_vcrb)   rd_mux = {2{16'(vcrb) & VCR_RMASK}};
    if (sel_vcrc)   rd_mux = {2{16'(vcrc) & VCR_RMASK}};
    if (sel_vcrd)   rd_mux = {2{16'(vcrd) & VCRH_RMASK}};
    if (sel_vcrwdt) rd_mux = {2{16'(vcrwdt) & VCRH_RMASK}};
    if (sel_vcrdiv) rd_mux = 32'(vcrdiv) & VCRDIV_RMASK;
  end

  always_ff @(posedge CLK) begin
    if (RST)       reg_do <= 32'h0;
    else if (CE_F) reg_do <= rd_mux;
  end

  assign IBUS_DO = IBUS_ACT ? reg_do : 32'h0;

  logic [4*N_SRC-1:0] lvl_pk;
  logic [8*N_SRC-1:0] vec_pk;
  logic [3:0]         win_lvl;
  logic [7:0]         win_vec;
  logic               win_valid;

  // Concatenation runs MSB-first, so the list is INTC_SRC_t reversed
  assign lvl_pk = {
    FRT_OVI   ? iprb.frt  : 4'd0, FRT_OCI  ? iprb.frt  : 4'd0, FRT_ICI  ? iprb.frt  : 4'd0,
    SCI_TEI   ? iprb.sci  : 4'd0, SCI_TXI  ? iprb.sci  : 4'd0, SCI_RXI  ? iprb.sci  : 4'd0,
    SCI_ERI   ? iprb.sci  : 4'd0, WDT_ITI  ? ipra.wdt  : 4'd0, DMA1_IRQ ? ipra.dmac : 4'd0,
    DMA0_IRQ  ? ipra.dmac : 4'd0, DIVU_OVFI ? ipra.divu : 4'd0
  };
  assign vec_pk = {
    {1'b0, vcrd.hi}, {1'b0, vcrc.lo}, {1'b0, vcrc.hi}, {1'b0, vcrb.lo}, {1'b0, vcrb.hi},
    {1'b0, vcra.lo}, {1'b0, vcra.hi}, {1'b0, vcrwdt.hi}, DMA1_VEC, DMA0_VEC, {1'b0, vcrdiv.vec}
  };

  sh_intc_prio_sel u_prio_sel (
    .lvl_in    (lvl_pk),
    .vec_in    (vec_pk),
    .win_lvl   (win_lvl),
    .win_vec   (win_vec),
    .win_valid (win_valid)
  );

  logic       snap_valid;
  logic [7:0] snap_vec;
  logic       ack_hold;

  // Snapshot is held on the acknowledge cycle and the one after it
  always_ff @(posedge CLK) begin
    if (RST) begin
      INT_LVL    <= 4'd0;
      snap_valid <= 1'b0;
      snap_vec   <= 8'd0;
      ack_hold   <= 1'b0;
    end else if (CE_R) begin
      ack_hold <= INT_ACK;
      if (INT_ACK) begin
        if (!snap_valid) snap_vec <= SPURIOUS_VEC;
      end else if (!ack_hold) begin
        INT_LVL    <= win_lvl;
        snap_valid <= win_valid;
        snap_vec   <= win_vec;
      end
    end
  end

  assign INT_VEC = snap_vec;

endmodule

// File: tb/tb_sh_onchip_intc.sv
// tb/tb_sh_onchip_intc.sv - directed self-checking bench for sh_onchip_intc
module tb_sh_onchip_intc;

  logic        CLK = 1'b0;
  logic        RST, CE_R, CE_F;
  logic [31:0] IBUS_A, IBUS_DI, IBUS_DO;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT;
  logic        SCI_ERI, SCI_RXI, SCI_TXI, SCI_TEI;
  logic        FRT_ICI, FRT_OCI, FRT_OVI;
  logic        WDT_ITI, DIVU_OVFI, DMA0_IRQ, DMA1_IRQ;
  logic [7:0]  DMA0_VEC, DMA1_VEC;
  logic [3:0]  INT_LVL;
  logic [7:0]  INT_VEC;
  logic        INT_ACK;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  sh_onchip_intc #(.SPURIOUS_VEC(8'd24)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F),
    .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
    .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
    .SCI_ERI(SCI_ERI), .SCI_RXI(SCI_RXI), .SCI_TXI(SCI_TXI), .SCI_TEI(SCI_TEI),
    .FRT_ICI(FRT_ICI), .FRT_OCI(FRT_OCI), .FRT_OVI(FRT_OVI),
    .WDT_ITI(WDT_ITI), .DIVU_OVFI(DIVU_OVFI), .DMA0_IRQ(DMA0_IRQ), .DMA1_IRQ(DMA1_IRQ),
    .DMA0_VEC(DMA0_VEC), .DMA1_VEC(DMA1_VEC),
    .INT_LVL(INT_LVL), .INT_VEC(INT_VEC), .INT_ACK(INT_ACK)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ibus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba);
    IBUS_A = a; IBUS_DI = d; IBUS_BA = ba; IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
    tick();
    IBUS_WE = 1'b0; IBUS_REQ = 1'b0; IBUS_BA = 4'h0;
  endtask

  task automatic ibus_read(input logic [31:0] a, output logic [31:0] d);
    IBUS_A = a; IBUS_BA = 4'hF; IBUS_WE = 1'b0; IBUS_REQ = 1'b1;
    tick();
    d = IBUS_DO;
    IBUS_REQ = 1'b0; IBUS_BA = 4'h0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    n_checks++; if (INT_LVL !== 4'd0) begin n_fail++; $display("FAIL reset_lvl: got %0d expected 0", INT_LVL); end
    n_checks++; if (INT_VEC !== 8'd0) begin n_fail++; $display("FAIL reset_vec: got %h expected 00", INT_VEC); end
    n_checks++; if (IBUS_DO !== 32'h0) begin n_fail++; $display("FAIL reset_do: got %h expected 0", IBUS_DO); end
    n_checks++; if (IBUS_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", IBUS_BUSY); end
  endtask

  task automatic test_basic();
    ibus_write(32'hFFFF_FE60, 32'hA000_0000, 4'b1100);
    ibus_write(32'hFFFF_FE62, 32'h0000_4344, 4'b0011);
    SCI_RXI = 1'b1;
    tick();
    n_checks++; if (INT_LVL !== 4'd10) begin n_fail++; $display("FAIL basic_lvl: got %0d expected 10", INT_LVL); end
    n_checks++; if (INT_VEC !== 8'h44) begin n_fail++; $display("FAIL basic_vec: got %h expected 44", INT_VEC); end
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    n_checks++; if (INT_VEC !== 8'h44) begin n_fail++; $display("FAIL ack_hold1: got %h expected 44", INT_VEC); end
    tick();
    n_checks++; if (INT_VEC !== 8'h44) begin n_fail++; $display("FAIL ack_hold2: got %h expected 44", INT_VEC); end
    SCI_RXI = 1'b0;
    tick(); tick();
    n_checks++; if (INT_LVL !== 4'd0) begin n_fail++; $display("FAIL basic_idle_lvl: got %0d expected 0", INT_LVL); end
  endtask

  task automatic test_tie_order();
    ibus_write(32'hFFFF_FEE2, 32'h0000_0A00, 4'b0011);
    DMA0_VEC = 8'h60; DMA0_IRQ = 1'b1; SCI_ERI = 1'b1;
    tick();
    n_checks++; if (INT_VEC !== 8'h60) begin n_fail++; $display("FAIL tie_dma0: got %h expected 60", INT_VEC); end
    n_checks++; if (INT_LVL !== 4'd10) begin n_fail++; $display("FAIL tie_lvl: got %0d expected 10", INT_LVL); end
    DMA0_IRQ = 1'b0;
    tick();
    n_checks++; if (INT_VEC !== 8'h43) begin n_fail++; $display("FAIL tie_eri: got %h expected 43", INT_VEC); end
    ibus_write(32'hFFFF_FE60, 32'hAC00_0000, 4'b1100);
    ibus_write(32'hFFFF_FE68, 32'h5500_0000, 4'b1100);
    FRT_OVI = 1'b1;
    tick();
    n_checks++; if (INT_VEC !== 8'h55) begin n_fail++; $display("FAIL level_beats_order_vec: got %h expected 55", INT_VEC); end
    n_checks++; if (INT_LVL !== 4'd12) begin n_fail++; $display("FAIL level_beats_order_lvl: got %0d expected 12", INT_LVL); end
    SCI_ERI = 1'b0; FRT_OVI = 1'b0;
    tick();
  endtask

  task automatic test_mask();
    ibus_write(32'hFFFF_FE60, 32'h5000_0000, 4'b1100);
    ibus_write(32'hFFFF_FE64, 32'h0021_0000, 4'b1100);
    SCI_TEI = 1'b1;
    tick();
    n_checks++; if (INT_LVL !== 4'd5) begin n_fail++; $display("FAIL mask_pre_lvl: got %0d expected 5", INT_LVL); end
    n_checks++; if (INT_VEC !== 8'h21) begin n_fail++; $display("FAIL mask_pre_vec: got %h expected 21", INT_VEC); end
    ibus_write(32'hFFFF_FE60, 32'h0000_0000, 4'b1100);
    n_checks++; if (INT_LVL !== 4'd5) begin n_fail++; $display("FAIL mask_write_edge: got %0d expected 5", INT_LVL); end
    tick();
    n_checks++; if (INT_LVL !== 4'd0) begin n_fail++; $display("FAIL mask_after: got %0d expected 0", INT_LVL); end
    SCI_TEI = 1'b0;
    tick();
  endtask

  task automatic test_ack_edges();
    ibus_write(32'hFFFF_FE60, 32'hA000_0000, 4'b1100);
    SCI_RXI = 1'b1;
    tick();
    n_checks++; if (INT_VEC !== 8'h44) begin n_fail++; $display("FAIL drop_pre: got %h expected 44", INT_VEC); end
    INT_ACK = 1'b1; SCI_RXI = 1'b0;
    tick();
    INT_ACK = 1'b0;
    n_checks++; if (INT_VEC !== 8'h44) begin n_fail++; $display("FAIL drop_ack: got %h expected 44", INT_VEC); end
    tick(); tick();
    n_checks++; if (INT_LVL !== 4'd0) begin n_fail++; $display("FAIL drop_idle: got %0d expected 0", INT_LVL); end
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    n_checks++; if (INT_VEC !== 8'd24) begin n_fail++; $display("FAIL spurious: got %0d expected 24", INT_VEC); end
    tick(); tick();
    SCI_RXI = 1'b1;
    tick();
    IBUS_A = 32'hFFFF_FE62; IBUS_DI = 32'h0000_4355; IBUS_BA = 4'b0011;
    IBUS_WE = 1'b1; IBUS_REQ = 1'b1; INT_ACK = 1'b1;
    tick();
    IBUS_WE = 1'b0; IBUS_REQ = 1'b0; IBUS_BA = 4'h0; INT_ACK = 1'b0;
    n_checks++; if (INT_VEC !== 8'h44) begin n_fail++; $display("FAIL wr_ack_frozen: got %h expected 44", INT_VEC); end
    tick();
    n_checks++; if (INT_VEC !== 8'h44) begin n_fail++; $display("FAIL wr_ack_frozen2: got %h expected 44", INT_VEC); end
    tick();
    n_checks++; if (INT_VEC !== 8'h55) begin n_fail++; $display("FAIL wr_ack_commit: got %h expected 55", INT_VEC); end
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0; DMA0_VEC = 8'h60; DMA0_IRQ = 1'b1;
    n_checks++; if (INT_VEC !== 8'h55) begin n_fail++; $display("FAIL late_high_hold1: got %h expected 55", INT_VEC); end
    tick();
    n_checks++; if (INT_VEC !== 8'h55) begin n_fail++; $display("FAIL late_high_hold2: got %h expected 55", INT_VEC); end
    tick();
    n_checks++; if (INT_VEC !== 8'h60) begin n_fail++; $display("FAIL late_high_report: got %h expected 60", INT_VEC); end
    DMA0_IRQ = 1'b0; SCI_RXI = 1'b0;
    tick(); tick();
  endtask

  task automatic test_registers();
    logic [31:0] rd;
    ibus_write(32'hFFFF_FE62, 32'h0000_4344, 4'b0011);
    ibus_write(32'hFFFF_FE62, 32'h0000_7F00, 4'b0010);
    ibus_read(32'hFFFF_FE62, rd);
    n_checks++; if (rd !== 32'h7F44_7F44) begin n_fail++; $display("FAIL rd_vcra_byte: got %h expected 7f447f44", rd); end
    n_checks++; if (IBUS_ACT !== 1'b1) begin n_fail++; $display("FAIL act_hit: got %b expected 1", IBUS_ACT); end
    ibus_write(32'hFFFF_FEE2, 32'h0000_FFFF, 4'b0011);
    ibus_read(32'hFFFF_FEE2, rd);
    n_checks++; if (rd !== 32'hFFF0_FFF0) begin n_fail++; $display("FAIL rd_ipra: got %h expected fff0fff0", rd); end
    ibus_write(32'hFFFF_FF0C, 32'hFFFF_FFFF, 4'b1111);
    ibus_read(32'hFFFF_FF0C, rd);
    n_checks++; if (rd !== 32'h0000_007F) begin n_fail++; $display("FAIL rd_vcrdiv: got %h expected 0000007f", rd); end
    CE_R = 1'b0;
    ibus_write(32'hFFFF_FE64, 32'h1234_0000, 4'b1100);
    CE_R = 1'b1;
    ibus_read(32'hFFFF_FE64, rd);
    n_checks++; if (rd !== 32'h0021_0021) begin n_fail++; $display("FAIL ce_r_gate: got %h expected 00210021", rd); end
    ibus_write(32'hFFFF_FE60, 32'h3C00_0000, 4'b1000);
    ibus_read(32'hFFFF_FE60, rd);
    n_checks++; if (rd !== 32'h3C00_3C00) begin n_fail++; $display("FAIL rd_iprb_byte: got %h expected 3c003c00", rd); end
    ibus_read(32'hFFFF_FE70, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rd_unmapped: got %h expected 0", rd); end
    n_checks++; if (IBUS_ACT !== 1'b0) begin n_fail++; $display("FAIL act_miss: got %b expected 0", IBUS_ACT); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    ibus_write(32'hFFFF_FE60, 32'hA000_0000, 4'b1100);
    SCI_RXI = 1'b1;
    tick();
    n_checks++; if (INT_LVL !== 4'd10) begin n_fail++; $display("FAIL rst_pre_lvl: got %0d expected 10", INT_LVL); end
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0; IBUS_A = 32'hFFFF_FE62; IBUS_REQ = 1'b1; RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++; if (INT_LVL !== 4'd0) begin n_fail++; $display("FAIL rst_lvl: got %0d expected 0", INT_LVL); end
    n_checks++; if (INT_VEC !== 8'd0) begin n_fail++; $display("FAIL rst_vec: got %h expected 00", INT_VEC); end
    n_checks++; if (IBUS_DO !== 32'h0) begin n_fail++; $display("FAIL rst_do: got %h expected 0", IBUS_DO); end
    IBUS_REQ = 1'b0;
    ibus_read(32'hFFFF_FE62, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_vcra: got %h expected 0", rd); end
    ibus_read(32'hFFFF_FE60, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_iprb: got %h expected 0", rd); end
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    n_checks++; if (INT_VEC !== 8'd24) begin n_fail++; $display("FAIL rst_spurious: got %0d expected 24", INT_VEC); end
    n_checks++; if (INT_LVL !== 4'd0) begin n_fail++; $display("FAIL rst_ack_lvl: got %0d expected 0", INT_LVL); end
    SCI_RXI = 1'b0;
  endtask

  initial begin
    RST = 1'b1; CE_R = 1'b1; CE_F = 1'b1;
    IBUS_A = 32'h0; IBUS_DI = 32'h0; IBUS_BA = 4'h0; IBUS_WE = 1'b0; IBUS_REQ = 1'b0;
    SCI_ERI = 1'b0; SCI_RXI = 1'b0; SCI_TXI = 1'b0; SCI_TEI = 1'b0;
    FRT_ICI = 1'b0; FRT_OCI = 1'b0; FRT_OVI = 1'b0;
    WDT_ITI = 1'b0; DIVU_OVFI = 1'b0; DMA0_IRQ = 1'b0; DMA1_IRQ = 1'b0;
    DMA0_VEC = 8'h00; DMA1_VEC = 8'h00; INT_ACK = 1'b0;
    test_reset();
    test_basic();
    test_tie_order();
    test_mask();
    test_ack_edges();
    test_registers();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
